// File: rtl/pipeline_control_sb.sv
// Hazard/flush controller for the Aquila pipeline: multi-bubble load-use detection,
// a long-latency (MUL/DIV) register scoreboard and a saturating hazard-cycle counter.
module pipeline_control_sb #(
    parameter int unsigned NUM_REGS         = 32,
    parameter int unsigned LOAD_USE_BUBBLES = 1,
    parameter bit          BPU_EN           = 1'b1,
    parameter int unsigned CNT_WIDTH        = 32,
    localparam int unsigned AW              = $clog2(NUM_REGS)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 stall_i,
    input  logic                 dec_valid_i,
    input  logic [AW-1:0]        rs1_addr_i,
    input  logic [AW-1:0]        rs2_addr_i,
    input  logic                 rs1_used_i,
    input  logic                 rs2_used_i,
    input  logic [AW-1:0]        dec_rd_addr_i,
    input  logic                 dec_rd_we_i,
    input  logic                 illegal_instr_i,
    input  logic                 exe_valid_i,
    input  logic [AW-1:0]        rd_addr_DEC_EXE_i,
    input  logic                 is_load_DEC_EXE_i,
    input  logic                 is_long_DEC_EXE_i,
    input  logic                 wb_long_valid_i,
    input  logic [AW-1:0]        wb_long_rd_i,
    input  logic                 branch_taken_i,
    input  logic                 cond_branch_hit_i,
    input  logic                 uncond_branch_hit_i,
    input  logic                 cond_branch_misprediction_i,
    input  logic                 sys_jump_i,
    output logic                 flush2fet_o,
    output logic                 flush2dec_o,
    output logic                 stall_from_hazard_o,
    output logic [NUM_REGS-1:0]  pending_regs_o,
    output logic [CNT_WIDTH-1:0] hazard_cycles_o
);

    localparam int unsigned DEPTH = (LOAD_USE_BUBBLES > 1) ? LOAD_USE_BUBBLES - 1 : 1;

    logic                     exe_rd_nz;
    logic                     ld_s0;
    logic                     long_s0;
    logic                     branch_flush;
    logic [DEPTH-1:0]         lp_v;
    logic [DEPTH-1:0][AW-1:0] lp_rd;
    logic [NUM_REGS-1:0]      pending_q;
    logic [NUM_REGS-1:0]      pending_d;
    logic [CNT_WIDTH-1:0]     cnt_q;
    logic                     ld_haz;
    logic                     long_haz;
    logic                     hazard;

    always_comb begin
        exe_rd_nz = (rd_addr_DEC_EXE_i != '0);
        ld_s0     = exe_valid_i & is_load_DEC_EXE_i & exe_rd_nz;
        long_s0   = exe_valid_i & is_long_DEC_EXE_i & exe_rd_nz;
        if (BPU_EN)
            branch_flush = (branch_taken_i & ~cond_branch_hit_i & ~uncond_branch_hit_i)
                         | cond_branch_misprediction_i;
        else
            branch_flush = branch_taken_i;
    end

    // Stage 0 is the live EXE load; lp_v/lp_rd[i] hold stage i+1 (constant empty when one bubble)
    generate
        if (LOAD_USE_BUBBLES > 1) begin : g_load_pipe
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    lp_v  <= '0;
                    lp_rd <= '0;
                end else if (!stall_i) begin
                    lp_v[0]  <= ld_s0;
                    lp_rd[0] <= rd_addr_DEC_EXE_i;
                    for (int unsigned i = 1; i < DEPTH; i++) begin
                        lp_v[i]  <= lp_v[i-1];
                        lp_rd[i] <= lp_rd[i-1];
                    end
                end
            end
        end else begin : g_no_load_pipe
            assign lp_v  = '0;
            assign lp_rd = '0;
        end
    endgenerate

    // Valid entries always carry a non-zero rd, so x0 sources can never match
    always_comb begin
        ld_haz = ld_s0 & ((rs1_used_i & (rs1_addr_i == rd_addr_DEC_EXE_i)) |
                          (rs2_used_i & (rs2_addr_i == rd_addr_DEC_EXE_i)));
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (lp_v[i] && ((rs1_used_i && (rs1_addr_i == lp_rd[i])) ||
                            (rs2_used_i && (rs2_addr_i == lp_rd[i]))))
                ld_haz = 1'b1;
        end
    end

    always_comb begin
        long_haz = (rs1_used_i & (pending_q[rs1_addr_i] | (long_s0 & (rs1_addr_i == rd_addr_DEC_EXE_i))))
                 | (rs2_used_i & (pending_q[rs2_addr_i] | (long_s0 & (rs2_addr_i == rd_addr_DEC_EXE_i))))
                 | (dec_rd_we_i & pending_q[dec_rd_addr_i]);
        hazard   = dec_valid_i & (ld_haz | long_haz) & ~branch_flush & ~sys_jump_i;
    end

    // Clear applied first so a same-cycle set of the same register wins
    always_comb begin
        pending_d = pending_q;
        if (wb_long_valid_i)
            pending_d[wb_long_rd_i] = 1'b0;
        if (long_s0 && !stall_i && !branch_flush)
            pending_d[rd_addr_DEC_EXE_i] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            pending_q <= pending_d;
            if (hazard && !stall_i && (cnt_q != '1))
                cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    always_comb begin
        flush2fet_o         = ~rst_i & (branch_flush | sys_jump_i);
        flush2dec_o         = ~rst_i & (branch_flush | hazard | illegal_instr_i);
        stall_from_hazard_o = ~rst_i & hazard;
        pending_regs_o      = rst_i ? '0 : pending_q;
        hazard_cycles_o     = rst_i ? '0 : cnt_q;
    end

endmodule

// File: tb/tb_pipeline_control_sb.sv
// Bench for pipeline_control_sb: two configurations driven in lockstep and compared
// against a per-register blocking-time model of loads, long ops and the counter.
module tb_pipeline_control_sb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, stall, dec_v, u1, u2, dec_we, ill, exe_v, is_load, is_long, wb_v;
    logic       bt, ch, uh, mis, sj;
    logic [4:0] rs1, rs2, dec_rd, exe_rd, wb_rd;

    logic        f2f [2];
    logic        f2d [2];
    logic        stl [2];
    logic [31:0] pend [2];
    logic [31:0] hc_a;
    logic [2:0]  hc_b;

    pipeline_control_sb #(.NUM_REGS(32), .LOAD_USE_BUBBLES(3), .BPU_EN(1'b1), .CNT_WIDTH(32)) u_dut_a (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .dec_valid_i(dec_v),
        .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
        .dec_rd_addr_i(dec_rd), .dec_rd_we_i(dec_we), .illegal_instr_i(ill),
        .exe_valid_i(exe_v), .rd_addr_DEC_EXE_i(exe_rd), .is_load_DEC_EXE_i(is_load),
        .is_long_DEC_EXE_i(is_long), .wb_long_valid_i(wb_v), .wb_long_rd_i(wb_rd),
        .branch_taken_i(bt), .cond_branch_hit_i(ch), .uncond_branch_hit_i(uh),
        .cond_branch_misprediction_i(mis), .sys_jump_i(sj),
        .flush2fet_o(f2f[0]), .flush2dec_o(f2d[0]), .stall_from_hazard_o(stl[0]),
        .pending_regs_o(pend[0]), .hazard_cycles_o(hc_a));

    pipeline_control_sb #(.NUM_REGS(32), .LOAD_USE_BUBBLES(1), .BPU_EN(1'b0), .CNT_WIDTH(3)) u_dut_b (
        .clk_i(clk), .rst_i(rst), .stall_i(stall), .dec_valid_i(dec_v),
        .rs1_addr_i(rs1), .rs2_addr_i(rs2), .rs1_used_i(u1), .rs2_used_i(u2),
        .dec_rd_addr_i(dec_rd), .dec_rd_we_i(dec_we), .illegal_instr_i(ill),
        .exe_valid_i(exe_v), .rd_addr_DEC_EXE_i(exe_rd), .is_load_DEC_EXE_i(is_load),
        .is_long_DEC_EXE_i(is_long), .wb_long_valid_i(wb_v), .wb_long_rd_i(wb_rd),
        .branch_taken_i(bt), .cond_branch_hit_i(ch), .uncond_branch_hit_i(uh),
        .cond_branch_misprediction_i(mis), .sys_jump_i(sj),
        .flush2fet_o(f2f[1]), .flush2dec_o(f2d[1]), .stall_from_hazard_o(stl[1]),
        .pending_regs_o(pend[1]), .hazard_cycles_o(hc_b));

    // Model state: remaining cycles each register stays blocked by a retired load
    int     lub [2]  = '{3, 1};
    bit     bpu [2]  = '{1'b1, 1'b0};
    longint cmax [2] = '{64'hFFFF_FFFF, 64'd7};
    int     lblk [2][32];
    bit     busy [2][32];
    longint cnt [2];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit bflush(int k);
        return bpu[k] ? ((bt && !ch && !uh) || mis) : bt;
    endfunction

    function automatic bit src_hit(int k, logic [4:0] a, logic used);
        if (!used || a == 5'd0) return 1'b0;
        return (lblk[k][a] > 0) || busy[k][a] || (exe_v && (is_load || is_long) && exe_rd == a);
    endfunction

    function automatic bit mhaz(int k);
        return !rst && dec_v && !bflush(k) && !sj &&
               (src_hit(k, rs1, u1) || src_hit(k, rs2, u2) || (dec_we && busy[k][dec_rd]));
    endfunction

    task automatic step();
        logic [31:0] pexp;
        logic [63:0] hgot;
        bit h, bf;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            for (int r = 0; r < 32; r++) pexp[r] = busy[k][r];
            hgot = (k == 0) ? 64'(hc_a) : 64'(hc_b);
            chk($sformatf("flush2fet[%0d]", k), 64'(f2f[k]), 64'(!rst && (bflush(k) || sj)));
            chk($sformatf("flush2dec[%0d]", k), 64'(f2d[k]), 64'(!rst && (bflush(k) || mhaz(k) || ill)));
            chk($sformatf("stall[%0d]", k), 64'(stl[k]), 64'(mhaz(k)));
            chk($sformatf("pending[%0d]", k), 64'(pend[k]), rst ? 64'd0 : 64'(pexp));
            chk($sformatf("hazcnt[%0d]", k), hgot, rst ? 64'd0 : 64'(cnt[k]));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                cnt[k] = 0;
                for (int r = 0; r < 32; r++) begin lblk[k][r] = 0; busy[k][r] = 1'b0; end
            end else begin
                h  = mhaz(k);
                bf = bflush(k);
                if (!stall && h && cnt[k] < cmax[k]) cnt[k]++;
                if (!stall) begin
                    for (int r = 0; r < 32; r++) if (lblk[k][r] > 0) lblk[k][r]--;
                    if (exe_v && is_load && exe_rd != 5'd0) lblk[k][exe_rd] = lub[k] - 1;
                end
                if (wb_v) busy[k][wb_rd] = 1'b0;
                if (exe_v && is_long && exe_rd != 5'd0 && !stall && !bf) busy[k][exe_rd] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        stall = 0; dec_v = 0; u1 = 0; u2 = 0; dec_we = 0; ill = 0; exe_v = 0;
        is_load = 0; is_long = 0; wb_v = 0; bt = 0; ch = 0; uh = 0; mis = 0; sj = 0;
        rs1 = '0; rs2 = '0; dec_rd = '0; exe_rd = '0; wb_rd = '0;
    endtask

    function automatic logic [4:0] rsel();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 4));
    endfunction

    initial begin
        idle();
        rst = 1;
        step(); step();
        rst = 0;
        // load x5 then dependent rs1 = x5
        exe_v = 1; is_load = 1; exe_rd = 5'd5; dec_v = 1; rs1 = 5'd5; u1 = 1; step();
        exe_v = 0; is_load = 0; repeat (3) step();
        // load x7 with a two-cycle memory stall mid-sequence
        idle(); exe_v = 1; is_load = 1; exe_rd = 5'd7; dec_v = 1; rs1 = 5'd7; u1 = 1; step();
        exe_v = 0; is_load = 0; step();
        stall = 1; step(); step();
        stall = 0; repeat (3) step();
        // DIV to x10, dependent read, writeback, then same-cycle re-issue
        idle(); exe_v = 1; is_long = 1; exe_rd = 5'd10; dec_v = 1; rs2 = 5'd10; u2 = 1; step();
        exe_v = 0; is_long = 0; repeat (3) step();
        wb_v = 1; wb_rd = 5'd10; step();
        wb_v = 0; step();
        exe_v = 1; is_long = 1; step();
        wb_v = 1; step();
        idle(); dec_v = 1; dec_we = 1; dec_rd = 5'd10; step();
        wb_v = 1; wb_rd = 5'd10; step();
        // x0 never participates
        idle(); exe_v = 1; is_load = 1; dec_v = 1; u1 = 1; step();
        is_load = 0; is_long = 1; step();
        idle(); dec_v = 1; u1 = 1; step();
        // branch resolution with a simultaneous load-use
        idle(); exe_v = 1; is_load = 1; exe_rd = 5'd3; dec_v = 1; rs1 = 5'd3; u1 = 1;
        bt = 1; ch = 1; step();
        mis = 1; step();
        ch = 0; mis = 0; step();
        uh = 1; step();
        idle(); sj = 1; step();
        sj = 0; ill = 1; step();
        // reset while a DIV is pending under a memory stall
        idle(); exe_v = 1; is_long = 1; exe_rd = 5'd12; step();
        idle(); dec_v = 1; rs1 = 5'd12; u1 = 1; stall = 1; step();
        rst = 1; step();
        rst = 0; stall = 0; step(); step();
        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            rst     = ($urandom_range(0, 199) == 0);
            stall   = ($urandom_range(0, 4) == 0);
            dec_v   = ($urandom_range(0, 3) != 0);
            rs1     = rsel(); rs2 = rsel(); dec_rd = rsel();
            u1      = 1'($urandom_range(0, 1));
            u2      = 1'($urandom_range(0, 1));
            dec_we  = 1'($urandom_range(0, 1));
            ill     = ($urandom_range(0, 19) == 0);
            exe_v   = ($urandom_range(0, 3) != 0);
            exe_rd  = rsel();
            case ($urandom_range(0, 3))
                0: begin is_load = 1; is_long = 0; end
                1: begin is_load = 0; is_long = 1; end
                default: begin is_load = 0; is_long = 0; end
            endcase
            wb_v    = ($urandom_range(0, 5) == 0);
            wb_rd   = rsel();
            bt      = ($urandom_range(0, 7) == 0);
            ch      = 1'($urandom_range(0, 1));
            uh      = ($urandom_range(0, 3) == 0);
            mis     = ($urandom_range(0, 11) == 0);
            sj      = ($urandom_range(0, 29) == 0);
            step();
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
